// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Raster timing generator for the VGA simulation bench. Two free-running
// counters (hcnt, vcnt) walk the full raster. On each CLK edge with CE=1 the
// outputs register a decode of the current counter values, and then the
// counters advance. The output stage therefore lags the counters by exactly
// one enabled cycle, and every output comes straight from a flop.
//
// Line layout  : active | front porch | sync | back porch   (same for frames)
// Sync polarity: Hsync and Vsync are active low. Vsync covers whole lines,
//                porches included.
// Strobes      : line_start and frame_start are cleared on every CE=0 edge,
//                so each pulse is exactly one CLK wide even when CE is slow.
//
// Optional feature (compile-time macro VGA_TIMING_TEST_PATTERN_EN):
//   Adds R[4:0]/G[5:0]/B[4:0] ports carrying eight vertical colour bars
//   (white, yellow, cyan, green, magenta, red, blue, black). They are
//   registered in the same stage as DE and are zero outside the active area.
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int HSIZE = 640,  // active pixels per line
    parameter int HFP   = 16,   // horizontal front porch
    parameter int HSYNC = 96,   // horizontal sync width
    parameter int HBP   = 48,   // horizontal back porch
    parameter int VSIZE = 480,  // active lines per frame
    parameter int VFP   = 10,   // vertical front porch
    parameter int VSYNC = 2,    // vertical sync width
    parameter int VBP   = 33    // vertical back porch
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        CE,
    output logic        Hsync,
    output logic        Vsync,
    output logic        DE,
    output logic [11:0] hpos,
    output logic [11:0] vpos,
    output logic        line_start,
    output logic        frame_start
`ifdef VGA_TIMING_TEST_PATTERN_EN
    ,
    output logic [4:0]  R,
    output logic [5:0]  G,
    output logic [4:0]  B
`endif
);

    // Derived raster totals; not overridable.
    localparam int HTOTAL = HSIZE + HFP + HSYNC + HBP;
    localparam int VTOTAL = VSIZE + VFP + VSYNC + VBP;

    // Counter-width boundaries, precomputed so every compare is 12 bits wide.
    // A sync window is [START, END), END being the first pixel after sync.
    localparam logic [11:0] H_ACT        = 12'(HSIZE);
    localparam logic [11:0] H_SYNC_START = 12'(HSIZE + HFP);
    localparam logic [11:0] H_SYNC_END   = 12'(HSIZE + HFP + HSYNC);
    localparam logic [11:0] H_LAST       = 12'(HTOTAL - 1);
    localparam logic [11:0] V_ACT        = 12'(VSIZE);
    localparam logic [11:0] V_SYNC_START = 12'(VSIZE + VFP);
    localparam logic [11:0] V_SYNC_END   = 12'(VSIZE + VFP + VSYNC);
    localparam logic [11:0] V_LAST       = 12'(VTOTAL - 1);

`ifndef SYNTHESIS
    // Geometry sanity check for simulation; it builds no hardware.
    initial begin
        if (HSYNC < 1 || VSYNC < 1)
            $error("vga_timing_gen: HSYNC and VSYNC must be at least 1");
        if (HTOTAL > 4095 || VTOTAL > 4095)
            $error("vga_timing_gen: HTOTAL and VTOTAL must not exceed 4095");
    end
`endif

    // Raster position counters.
    logic [11:0] hcnt;
    logic [11:0] vcnt;

    // Combinational decode of the current position, captured by the output
    // stage on the next enabled edge.
    logic        de_d;
    logic        hsync_d;
    logic        vsync_d;
    logic        line_start_d;
    logic        frame_start_d;

`ifdef VGA_TIMING_TEST_PATTERN_EN
    logic [14:0] hcnt_x8;
    logic [2:0]  bar;
    logic [4:0]  r_d;
    logic [5:0]  g_d;
    logic [4:0]  b_d;
`endif

    // Advance hcnt every enabled cycle; vcnt steps only on the hcnt wrap, and
    // both wrap together at the last pixel of the frame.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (CE) begin
            // NOTE: non-blocking assignments here, so the decode below and the
            // output stage both see the pre-edge counter values.
            if (hcnt == H_LAST) begin
                hcnt <= '0;
                if (vcnt == V_LAST) begin
                    vcnt <= '0;
                end else begin
                    vcnt <= vcnt + 12'd1;
                end
            end else begin
                hcnt <= hcnt + 12'd1;
            end
        end
    end

    // Decode the current position into next-cycle output values.
    always_comb begin
        // NOTE: every signal gets an unconditional value first, so no path can
        // leave one unassigned and infer a latch.
        de_d          = 1'b0;
        hsync_d       = 1'b1;
        vsync_d       = 1'b1;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;

        de_d          = (hcnt < H_ACT) && (vcnt < V_ACT);
        hsync_d       = !((hcnt >= H_SYNC_START) && (hcnt < H_SYNC_END));
        vsync_d       = !((vcnt >= V_SYNC_START) && (vcnt < V_SYNC_END));
        line_start_d  = (hcnt == '0);
        frame_start_d = (hcnt == '0) && (vcnt == '0);
    end

`ifdef VGA_TIMING_TEST_PATTERN_EN
    // Colour-bar decode. Bar index = hcnt*8/HSIZE, a multiply-then-divide so
    // bar edges stay exact when HSIZE is not a multiple of 8. The bar colour
    // sequence maps onto the index bits: red is off for bars 2,3,6,7, green is
    // off for bars 4..7, blue is off for the odd bars.
    always_comb begin
        hcnt_x8 = '0;
        bar     = '0;
        r_d     = '0;
        g_d     = '0;
        b_d     = '0;

        hcnt_x8 = {hcnt, 3'b000};
        bar     = 3'(hcnt_x8 / 15'(HSIZE));
        if (de_d) begin
            r_d = bar[1] ? 5'd0 : 5'd31;
            g_d = bar[2] ? 6'd0 : 6'd63;
            b_d = bar[0] ? 5'd0 : 5'd31;
        end
    end
`endif

    // Output stage: capture the decode on enabled edges; on disabled edges the
    // levels hold and the strobes drop so each pulse lasts one CLK.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            // NOTE: every output flop has a reset value; they drive sync lines
            // downstream and must come out of reset inactive.
            Hsync       <= 1'b1;
            Vsync       <= 1'b1;
            DE          <= 1'b0;
            hpos        <= '0;
            vpos        <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
`ifdef VGA_TIMING_TEST_PATTERN_EN
            R           <= '0;
            G           <= '0;
            B           <= '0;
`endif
        end else if (CE) begin
            Hsync       <= hsync_d;
            Vsync       <= vsync_d;
            DE          <= de_d;
            hpos        <= hcnt;
            vpos        <= vcnt;
            line_start  <= line_start_d;
            frame_start <= frame_start_d;
`ifdef VGA_TIMING_TEST_PATTERN_EN
            R           <= r_d;
            G           <= g_d;
            B           <= b_d;
`endif
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Two instances share CLK/RESET_N/CE: u_dut with the default 640x480
// geometry (line-level checks) and u_small with a tiny raster so whole
// frames fit in a short run. A reference model counts enabled edges since
// reset; the pixel shown after the n-th enabled edge is (n-1) mod frame, and
// every output follows from that index by plain arithmetic. A compare
// process checks both instances against it on every falling edge, and the
// main sequence adds hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    // Small raster: 16+2+3+3 = 24 pixels per line, 8+2+2+3 = 15 lines.
    localparam int S_HS = 16, S_HFP = 2, S_HSY = 3, S_HBP = 3;
    localparam int S_VS = 8,  S_VFP = 2, S_VSY = 2, S_VBP = 3;

    logic CLK;
    logic RESET_N;
    logic CE;

    logic        d_hsync, d_vsync, d_de, d_ls, d_fs;
    logic [11:0] d_hpos, d_vpos;
    logic        s_hsync, s_vsync, s_de, s_ls, s_fs;
    logic [11:0] s_hpos, s_vpos;
`ifdef VGA_TIMING_TEST_PATTERN_EN
    logic [4:0]  d_r, s_r;
    logic [5:0]  d_g, s_g;
    logic [4:0]  d_b, s_b;
`endif

    vga_timing_gen u_dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .CE          (CE),
        .Hsync       (d_hsync),
        .Vsync       (d_vsync),
        .DE          (d_de),
        .hpos        (d_hpos),
        .vpos        (d_vpos),
        .line_start  (d_ls),
        .frame_start (d_fs)
`ifdef VGA_TIMING_TEST_PATTERN_EN
        ,
        .R           (d_r),
        .G           (d_g),
        .B           (d_b)
`endif
    );

    vga_timing_gen #(
        .HSIZE(S_HS), .HFP(S_HFP), .HSYNC(S_HSY), .HBP(S_HBP),
        .VSIZE(S_VS), .VFP(S_VFP), .VSYNC(S_VSY), .VBP(S_VBP)
    ) u_small (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .CE          (CE),
        .Hsync       (s_hsync),
        .Vsync       (s_vsync),
        .DE          (s_de),
        .hpos        (s_hpos),
        .vpos        (s_vpos),
        .line_start  (s_ls),
        .frame_start (s_fs)
`ifdef VGA_TIMING_TEST_PATTERN_EN
        ,
        .R           (s_r),
        .G           (s_g),
        .B           (s_b)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Clock.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // CE driver, 2 time units after each rising edge.
    // mode 0: always 1, mode 1: random, mode 2: alternate 1,0,1,0.
    int ce_mode = 0;
    always @(posedge CLK) begin
        #2;
        case (ce_mode)
            0:       CE = 1'b1;
            1:       CE = 1'($urandom_range(0, 1));
            default: CE = ~CE;
        endcase
    end

    // Reference model state: enabled edges since reset, and whether the last
    // edge was enabled.
    int unsigned en_count = 0;
    logic        last_ce  = 1'b0;
    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            en_count = 0;
            last_ce  = 1'b0;
        end else begin
            if (CE) en_count++;
            last_ce = CE;
        end
    end

    // Colour bars from left to right as {R,G,B} on/off.
    logic [2:0] bar_rgb [8] = '{3'b111, 3'b110, 3'b011, 3'b010,
                                3'b101, 3'b100, 3'b001, 3'b000};

    task automatic check_inst(
        input string tag,
        input int hs, input int hfp, input int hsy, input int hbp,
        input int vs, input int vfp, input int vsy, input int vbp,
        input logic a_hsync, input logic a_vsync, input logic a_de,
        input logic [11:0] a_hpos, input logic [11:0] a_vpos,
        input logic a_ls, input logic a_fs
`ifdef VGA_TIMING_TEST_PATTERN_EN
        , input logic [4:0] a_r, input logic [5:0] a_g, input logic [4:0] a_b
`endif
    );
        int ht, vt, pix, h, v;
        logic e_hsync, e_vsync, e_de, e_ls, e_fs;
        ht = hs + hfp + hsy + hbp;
        vt = vs + vfp + vsy + vbp;
        if (en_count == 0) begin
            pix = 0; h = 0; v = 0;
            e_hsync = 1'b1; e_vsync = 1'b1; e_de = 1'b0;
            e_ls = 1'b0; e_fs = 1'b0;
        end else begin
            pix     = int'((en_count - 1) % int'(ht * vt));
            h       = pix % ht;
            v       = pix / ht;
            e_de    = (h < hs) && (v < vs);
            e_hsync = !((h >= hs + hfp) && (h < hs + hfp + hsy));
            e_vsync = !((v >= vs + vfp) && (v < vs + vfp + vsy));
            e_ls    = last_ce && (h == 0);
            e_fs    = last_ce && (pix == 0);
        end
        check({tag, "_hsync"},       32'(a_hsync), 32'(e_hsync));
        check({tag, "_vsync"},       32'(a_vsync), 32'(e_vsync));
        check({tag, "_de"},          32'(a_de),    32'(e_de));
        check({tag, "_hpos"},        32'(a_hpos),  32'(h));
        check({tag, "_vpos"},        32'(a_vpos),  32'(v));
        check({tag, "_line_start"},  32'(a_ls),    32'(e_ls));
        check({tag, "_frame_start"}, 32'(a_fs),    32'(e_fs));
`ifdef VGA_TIMING_TEST_PATTERN_EN
        begin
            logic [2:0] c;
            c = e_de ? bar_rgb[(h * 8) / hs] : 3'b000;
            check({tag, "_r"}, 32'(a_r), c[2] ? 32'd31 : 32'd0);
            check({tag, "_g"}, 32'(a_g), c[1] ? 32'd63 : 32'd0);
            check({tag, "_b"}, 32'(a_b), c[0] ? 32'd31 : 32'd0);
        end
`endif
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge CLK) begin
        check_inst("dut", 640, 16, 96, 48, 480, 10, 2, 33,
                   d_hsync, d_vsync, d_de, d_hpos, d_vpos, d_ls, d_fs
`ifdef VGA_TIMING_TEST_PATTERN_EN
                   , d_r, d_g, d_b
`endif
                  );
        check_inst("small", S_HS, S_HFP, S_HSY, S_HBP, S_VS, S_VFP, S_VSY, S_VBP,
                   s_hsync, s_vsync, s_de, s_hpos, s_vpos, s_ls, s_fs
`ifdef VGA_TIMING_TEST_PATTERN_EN
                   , s_r, s_g, s_b
`endif
                  );
    end

    // Main sequence with literal expectations.
    initial begin
        int de_cnt, hs_lo, hs_first, hs_last;
        int vs_lo, vs_first, vs_first_vp, vs_first_hp, sde_cnt;
        int ls_idx[$];
        int fs_idx[$];
        int per;
        logic found;

        RESET_N = 1'b0;
        CE      = 1'b1;
        ce_mode = 0;

        // Reset held for 10 cycles with CE=1.
        repeat (10) @(negedge CLK);
        check("rst_hsync",       32'(d_hsync), 32'd1);
        check("rst_vsync",       32'(d_vsync), 32'd1);
        check("rst_de",          32'(d_de),    32'd0);
        check("rst_hpos",        32'(d_hpos),  32'd0);
        check("rst_line_start",  32'(d_ls),    32'd0);
        check("rst_frame_start", 32'(d_fs),    32'd0);

        @(posedge CLK); #3 RESET_N = 1'b1;
        @(posedge CLK); @(negedge CLK);
        check("first_de",          32'(d_de),   32'd1);
        check("first_frame_start", 32'(d_fs),   32'd1);
        check("first_line_start",  32'(d_ls),   32'd1);
        check("first_hpos",        32'(d_hpos), 32'd0);
        check("first_vpos",        32'(d_vpos), 32'd0);

        // Two default lines; i is the pixel index since the first enabled edge.
        de_cnt = 0; hs_lo = 0; hs_first = -1; hs_last = -1;
        vs_lo = 0; vs_first = -1; vs_first_vp = -1; vs_first_hp = -1; sde_cnt = 0;
        for (int i = 0; i < 1600; i++) begin
            if (i > 0) @(negedge CLK);
            if (i < 800) begin
                if (d_de) de_cnt++;
                if (!d_hsync) begin
                    hs_lo++;
                    if (hs_first < 0) hs_first = i;
                    hs_last = i;
                end
            end
            if (d_ls) ls_idx.push_back(i);
            if (s_fs) fs_idx.push_back(i);
            if (i < 360) begin
                if (s_de) sde_cnt++;
                if (!s_vsync) begin
                    vs_lo++;
                    if (vs_first < 0) begin
                        vs_first    = i;
                        vs_first_vp = int'(s_vpos);
                        vs_first_hp = int'(s_hpos);
                    end
                end
            end
`ifdef VGA_TIMING_TEST_PATTERN_EN
            if (i == 0)   begin check("rgb0_r", 32'(d_r), 32'd31); check("rgb0_g", 32'(d_g), 32'd63); check("rgb0_b", 32'(d_b), 32'd31); end
            if (i == 80)  begin check("rgb80_r", 32'(d_r), 32'd31); check("rgb80_g", 32'(d_g), 32'd63); check("rgb80_b", 32'(d_b), 32'd0); end
            if (i == 639) begin check("rgb639_r", 32'(d_r), 32'd0); check("rgb639_g", 32'(d_g), 32'd0); check("rgb639_b", 32'(d_b), 32'd0); end
            if (i == 700) begin check("rgb_blank_r", 32'(d_r), 32'd0); check("rgb_blank_g", 32'(d_g), 32'd0); check("rgb_blank_b", 32'(d_b), 32'd0); end
`endif
        end
        check("line_de_cycles",     32'(de_cnt),   32'd640);
        check("line_hsync_cycles",  32'(hs_lo),    32'd96);
        check("line_hsync_first",   32'(hs_first), 32'd656);
        check("line_hsync_last",    32'(hs_last),  32'd751);
        check("line_start_count",   32'(ls_idx.size()), 32'd2);
        check("line_start_period",  32'((ls_idx.size() >= 2) ? ls_idx[1] - ls_idx[0] : -1), 32'd800);
        check("small_fs_count",     32'(fs_idx.size()), 32'd5);
        check("small_frame_period", 32'((fs_idx.size() >= 2) ? fs_idx[1] - fs_idx[0] : -1), 32'd360);
        check("small_vsync_cycles", 32'(vs_lo),       32'd48);
        check("small_vsync_first",  32'(vs_first),    32'd240);
        check("small_vsync_vpos",   32'(vs_first_vp), 32'd10);
        check("small_vsync_hpos",   32'(vs_first_hp), 32'd0);
        check("small_de_cycles",    32'(sde_cnt),     32'd128);

        // Random CE; the compare process covers freezing and strobe width.
        ce_mode = 1;
        repeat (3000) @(negedge CLK);

        // CE alternating 1,0,1,0: small frame period doubles to 720 CLK.
        ce_mode = 2;
        found = 1'b0;
        for (int k = 0; k < 1000 && !found; k++) begin
            @(negedge CLK);
            found = s_fs;
        end
        check("toggle_fs_seen", 32'(found), 32'd1);
        found = 1'b0; per = -1;
        for (int k = 1; k <= 2000 && !found; k++) begin
            @(negedge CLK);
            if (s_fs) begin
                found = 1'b1;
                per   = k;
            end
        end
        check("toggle_frame_period", 32'(per), 32'd720);

        // Mid-frame reset of the small raster at vpos=5, hpos=7.
        ce_mode = 0;
        found = 1'b0;
        for (int k = 0; k < 800 && !found; k++) begin
            @(negedge CLK);
            found = (s_vpos == 12'd5) && (s_hpos == 12'd7);
        end
        check("midreset_pos_seen", 32'(found), 32'd1);
        @(posedge CLK); #3 RESET_N = 1'b0;
        #1;
        check("midreset_hsync",       32'(s_hsync), 32'd1);
        check("midreset_vsync",       32'(s_vsync), 32'd1);
        check("midreset_de",          32'(s_de),    32'd0);
        check("midreset_hpos",        32'(s_hpos),  32'd0);
        check("midreset_vpos",        32'(s_vpos),  32'd0);
        check("midreset_line_start",  32'(s_ls),    32'd0);
        check("midreset_frame_start", 32'(s_fs),    32'd0);
        check("midreset_dut_hpos",    32'(d_hpos),  32'd0);
        @(posedge CLK); #3 RESET_N = 1'b1;
        @(posedge CLK); @(negedge CLK);
        check("restart_frame_start", 32'(s_fs),   32'd1);
        check("restart_de",          32'(s_de),   32'd1);
        check("restart_hpos",        32'(s_hpos), 32'd0);
        check("restart_vpos",        32'(s_vpos), 32'd0);

        // More random CE after the restart.
        ce_mode = 1;
        repeat (2000) @(negedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
